// File: rtl/sass_tx_fifo.sv
// -----------------------------------------------------------------------------
// sass_tx_fifo
//
// SASS serial transmitter with a small word FIFO in front of it. Words are
// accepted over a valid/ready handshake. Each word is sent on the single-wire
// line as one frame:
//   start bit (0), DATA_L data bits LSB first, optional even-parity bit,
//   end delimiter (0), then GAP_BITS idle-high bit times.
// Frames go out back-to-back for as long as the FIFO holds words.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset (line returns idle immediately)
//   in_valid  word offered on in_data
//   in_data   word to transmit (DATA_L bits)
//   in_ready  FIFO not full; a word is taken on an edge with in_valid & in_ready
//   ovf_clr   clears ovf
//   ovf       sticky flag: a word was offered while in_ready was low
//   level     number of words currently held in the FIFO
//   busy      a frame is in progress or words are waiting (registered)
//   s         serial line, registered, idle high
// -----------------------------------------------------------------------------
module sass_tx_fifo #(
    parameter int DATA_L     = 8,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int RANGE      = 1_000_000,
    parameter int T          = 300,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int GAP_BITS   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [DATA_L-1:0]               in_data,
    output logic                            in_ready,
    input  logic                            ovf_clr,
    output logic                            ovf,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
    output logic                            busy,
    output logic                            s
);

    // Cycles per bit. The product can exceed 32 bits for real clock rates,
    // so it is formed in 64-bit arithmetic before the division.
    localparam longint TD_L    = (longint'(CLK_FREQ) * longint'(T)) / longint'(RANGE);
    localparam int     TD      = int'(TD_L);
    localparam int     TCW     = (TD > 1) ? $clog2(TD) : 1;
    localparam int     BIW     = $clog2(DATA_L + 1);
    localparam int     LW      = $clog2(FIFO_DEPTH + 1);
    localparam int     PW      = $clog2(FIFO_DEPTH);
    localparam int     GAP_CYC = GAP_BITS * TD;
    localparam int     GCW     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    generate
        if (TD < 2) begin : g_bad_td
            $error("sass_tx_fifo: bit duration of %0d cycles is below 2", TD);
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sass_tx_fifo: FIFO_DEPTH %0d must be a power of 2 and >= 2", FIFO_DEPTH);
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_END,
        ST_GAP
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_L-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [LW-1:0]     level_reg;
    logic              push;
    logic              pop;
    logic [DATA_L-1:0] head;

    // Ready comes from the registered level only, so a pop in the same
    // cycle cannot let an extra word in.
    assign in_ready = (level_reg != LW'(FIFO_DEPTH));
    assign push     = in_valid & in_ready;
    // The head word must be loaded on the same edge it is popped, so the
    // read is asynchronous; the array is small enough for distributed RAM.
    assign head     = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ------------------------------------------------------------ overflow
    logic ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (in_valid && !in_ready) begin
            ovf_reg <= 1'b1;            // set has priority over clear
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    // ----------------------------------------------------------------- FSM
    state_t            state_reg;
    state_t            state_next;
    logic [TCW-1:0]    tick_reg;
    logic [BIW-1:0]    bit_idx_reg;
    logic [GCW-1:0]    gap_cnt_reg;
    logic [DATA_L-1:0] shift_reg;
    logic              parity_reg;
    logic              s_reg;
    logic              busy_reg;
    logic              line_value;
    logic              bit_end;
    logic              gap_end;

    assign bit_end = (tick_reg == TCW'(TD - 1));
    assign gap_end = (gap_cnt_reg == GCW'(GAP_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // line_value is the level the line should carry for the current state;
    // it is registered into s, so the line lags the state by one cycle.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        line_value = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                if (level_reg != '0) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                line_value = 1'b0;
                if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                line_value = shift_reg[0];
                if (bit_end && (bit_idx_reg == BIW'(DATA_L - 1))) begin
                    state_next = (PARITY_EN != 0) ? ST_PAR : ST_END;
                end
            end
            ST_PAR: begin
                line_value = parity_reg;
                if (bit_end) begin
                    state_next = ST_END;
                end
            end
            ST_END: begin
                line_value = 1'b0;
                if (bit_end) begin
                    state_next = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_end) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_reg    <= '0;
            bit_idx_reg <= '0;
            gap_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            s_reg       <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            s_reg    <= line_value;
            busy_reg <= (state_reg != ST_IDLE) || (level_reg != '0);

            // Bit-time and gap counters restart on every state change.
            if (state_next != state_reg) begin
                tick_reg    <= '0;
                gap_cnt_reg <= '0;
            end else if (state_reg == ST_GAP) begin
                gap_cnt_reg <= gap_cnt_reg + GCW'(1);
            end else if (state_reg != ST_IDLE) begin
                tick_reg <= bit_end ? '0 : tick_reg + TCW'(1);
            end

            if (pop) begin
                shift_reg   <= head;
                parity_reg  <= ^head;
                bit_idx_reg <= '0;
            end else if ((state_reg == ST_DATA) && bit_end) begin
                shift_reg   <= shift_reg >> 1;
                bit_idx_reg <= bit_idx_reg + BIW'(1);
            end
        end
    end

    assign s     = s_reg;
    assign busy  = busy_reg;
    assign ovf   = ovf_reg;
    assign level = level_reg;

endmodule
